// File: rtl/cpu_pkg.sv
// Shared encodings, FSM/ALU enums and small decode helpers for the multicycle core.
// Pure declarations: no latency, no flow control.
package cpu_pkg;

  localparam int NUM_REGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLT,
    ALU_XOR
  } alu_op_e;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  function automatic logic insn_legal(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (funct == FN_JR) || (funct == FN_ADD) ||
                     (funct == FN_SUB) || (funct == FN_SLT);
      OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_XORI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_SLT: r = {31'd0, $signed(a) < $signed(b)};
      ALU_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file, two combinational read ports, one write port at the clock edge; r0 reads 0.
// Latency: reads 0 cycles, write visible next cycle; no flow control.
module mc_regfile
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] answer_o
);

  logic [31:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];
  assign answer_o  = regs_q[2];

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset core sharing one req/ack memory port between fetch and load/store.
// Latency 2-5 states per instruction plus memory waits; FETCH/MEM hold request stable until mem_ack.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int unsigned         ADDR_W          = 30,
  parameter logic [ADDR_W-1:0]   RESET_PC        = '0,
  parameter bit                  TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              retire,
  output logic              trap,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       answer
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [31:0]       alu_q;
  logic [31:0]       mdr_q;

  instr_t ir;
  assign ir = instr_t'(ir_q);

  logic legal, is_jump, is_jr, is_branch, is_load, is_store;
  always_comb begin
    legal     = insn_legal(ir.op, ir.funct);
    is_jump   = (ir.op == OP_J) || (ir.op == OP_JAL);
    is_jr     = (ir.op == OP_RTYPE) && (ir.funct == FN_JR);
    is_branch = (ir.op == OP_BEQ) || (ir.op == OP_BNE);
    is_load   = (ir.op == OP_LW);
    is_store  = (ir.op == OP_SW);
  end

  logic [31:0] sext_imm, zext_imm;
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext_imm = {16'd0, ir_q[15:0]};

  alu_op_e     alu_op;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = sext_imm;
    if (ir.op == OP_RTYPE) begin
      alu_b = b_q;
      case (ir.funct)
        FN_SUB:  alu_op = ALU_SUB;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end else if (ir.op == OP_XORI) begin
      alu_op = ALU_XOR;
      alu_b  = zext_imm;
    end
  end
  assign alu_res = alu_eval(alu_op, a_q, alu_b);

  // pc_q already points past the current instruction, so branch and link are relative to pc+1.
  logic              branch_taken;
  logic [ADDR_W-1:0] br_target;
  logic [31:0]       pc_word, jump_word, link_addr;
  logic [ADDR_W-1:0] jump_target, jr_target, data_addr;
  logic [31:0]       rf_a, rf_b;

  assign branch_taken = (a_q == b_q) ^ (ir.op == OP_BNE);
  assign br_target    = pc_q + sext_imm[ADDR_W-1:0];
  assign pc_word      = 32'(pc_q);
  assign jump_word    = {pc_word[31:26], ir_q[25:0]};
  assign jump_target  = jump_word[ADDR_W-1:0];
  assign link_addr    = 32'({pc_q, 2'b00});
  assign jr_target    = rf_a[ADDR_W+1:2];
  assign data_addr    = alu_q[ADDR_W+1:2];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  always_comb begin
    rf_we    = ((state_q == DECODE) && (ir.op == OP_JAL)) || (state_q == WB);
    rf_waddr = (ir.op == OP_RTYPE) ? ir.rd : ir.rt;
    rf_wdata = is_load ? mdr_q : alu_q;
    if (ir.op == OP_JAL) begin
      rf_waddr = 5'd31;
      rf_wdata = link_addr;
    end
  end

  mc_regfile u_rf (
    .clk_i     (clk),
    .rst_n_i   (reset_n),
    .raddr_a_i (ir.rs),
    .raddr_b_i (ir.rt),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .answer_o  (answer)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_ack) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= DECODE;
          end
        end
        DECODE: begin
          a_q <= rf_a;
          b_q <= rf_b;
          if (!legal) begin
            state_q <= TRAP_ON_ILLEGAL ? TRAP : FETCH;
          end else if (is_jump) begin
            pc_q    <= jump_target;
            state_q <= FETCH;
          end else if (is_jr) begin
            pc_q    <= jr_target;
            state_q <= FETCH;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          alu_q <= alu_res;
          if (is_branch) begin
            if (branch_taken) pc_q <= br_target;
            state_q <= FETCH;
          end else if (is_load || is_store) begin
            state_q <= MEM;
          end else begin
            state_q <= WB;
          end
        end
        MEM: begin
          if (mem_ack) begin
            if (is_load) begin
              mdr_q   <= mem_rdata;
              state_q <= WB;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        WB:      state_q <= FETCH;
        TRAP:    state_q <= TRAP;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Request is gated by reset_n so an in-flight access vanishes the moment reset asserts.
  always_comb begin
    mem_req   = reset_n && ((state_q == FETCH) || (state_q == MEM));
    mem_we    = mem_req && (state_q == MEM) && is_store;
    mem_addr  = '0;
    if (mem_req) mem_addr = (state_q == MEM) ? data_addr : pc_q;
    mem_wdata = mem_we ? b_q : '0;
    retire    = ((state_q == DECODE) && (is_jump || is_jr || (!legal && !TRAP_ON_ILLEGAL))) ||
                ((state_q == EXEC) && is_branch) ||
                ((state_q == MEM) && is_store && mem_ack) ||
                (state_q == WB);
    trap      = (state_q == TRAP);
  end

  assign pc = pc_q;

  logic unused_bits;
  assign unused_bits = ^{ir.shamt, alu_q, jump_word, pc_word};

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench: each loaded instruction queues its expected pc/answer/cycle count, popped at retire.
module tb_multicycle_cpu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        mem_req, mem_we, mem_ack, retire, trap;
  logic [29:0] mem_addr, pc;
  logic [31:0] mem_wdata, mem_rdata, answer;

  logic        nt_req, nt_we, nt_ack, nt_retire, nt_trap;
  logic [29:0] nt_addr, nt_pc;
  logic [31:0] nt_wdata, nt_rdata, nt_answer;

  multicycle_cpu #(.ADDR_W(30), .RESET_PC(30'd0), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .retire(retire),
    .trap(trap), .pc(pc), .answer(answer)
  );

  multicycle_cpu #(.ADDR_W(30), .RESET_PC(30'd0), .TRAP_ON_ILLEGAL(1'b0)) dut_nt (
    .clk(clk), .reset_n(reset_n), .mem_req(nt_req), .mem_we(nt_we), .mem_addr(nt_addr),
    .mem_wdata(nt_wdata), .mem_rdata(nt_rdata), .mem_ack(nt_ack), .retire(nt_retire),
    .trap(nt_trap), .pc(nt_pc), .answer(nt_answer)
  );

  // Memory for the main core: reads of word 2 are delayed by rd_delay cycles.
  logic [31:0] mem [0:255];
  int          wait_cnt = 0;
  int          rd_delay = 0;
  logic        force_ack = 1'b0;

  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_ack   = force_ack |
                     (mem_req && (mem_we || (mem_addr != 30'd2) || (wait_cnt >= rd_delay)));

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
    if (mem_req && mem_we && mem_ack) mem[mem_addr[7:0]] <= mem_wdata;
  end

  // Fixed program for the non-trapping core: illegal word, ADDI r2,r0,7, then J 2 forever.
  assign nt_rdata = (nt_addr == 30'd0) ? 32'hFC00_0000 :
                    (nt_addr == 30'd1) ? 32'h2002_0007 : 32'h0800_0002;
  assign nt_ack   = nt_req;

  int          w_cnt = 0, rd2_cyc = 0, hs_viol = 0;
  logic [29:0] w_addr = '0;
  logic [31:0] w_data = '0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [29:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  always @(negedge clk) begin
    if (mem_req && mem_we) begin
      w_cnt  <= w_cnt + 1;
      w_addr <= mem_addr;
      w_data <= mem_wdata;
    end
    if (mem_req && !mem_we && (mem_addr == 30'd2)) rd2_cyc <= rd2_cyc + 1;
    if (prev_req && !prev_ack && mem_req &&
        ((mem_addr != prev_addr) || (mem_we != prev_we) || (mem_wdata != prev_wdata)))
      hs_viol <= hs_viol + 1;
    prev_req   <= mem_req;
    prev_ack   <= mem_ack;
    prev_we    <= mem_we;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
  end

  int          nt_cyc = 0, nt_first = 0, nt_wcnt = 0;
  logic [29:0] nt_pc3 = '1;
  logic [31:0] nt_ans3 = '1;

  always @(negedge clk) begin
    if (!reset_n) begin
      nt_cyc <= 0;
    end else begin
      nt_cyc <= nt_cyc + 1;
      if (nt_retire && (nt_first == 0)) nt_first <= nt_cyc + 1;
      if (nt_cyc + 1 == 3) begin
        nt_pc3  <= nt_pc;
        nt_ans3 <= nt_answer;
      end
      if (nt_req && nt_we) nt_wcnt <= nt_wcnt + 1;
    end
  end

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [29:0] pc;
    logic [31:0] ans;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic expect_retire(input string tag, input logic [29:0] epc,
                               input logic [31:0] eans, input int ecyc);
    exp_t e;
    e.tag = tag;
    e.pc  = epc;
    e.ans = eans;
    e.cyc = ecyc;
    sb_q.push_back(e);
  endtask

  task automatic put(input string tag, input int addr, input logic [31:0] instr,
                     input logic [29:0] epc, input logic [31:0] eans, input int ecyc);
    mem[addr] = instr;
    expect_retire(tag, epc, eans, ecyc);
  endtask

  // Cycle 1 of each instruction is the sample after the previous retire.
  task automatic drain();
    exp_t e;
    int   cyc;
    bit   seen;
    cyc = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        cyc++;
        if (retire) begin
          seen = 1'b1;
          break;
        end
      end
      check({e.tag, "_retire"}, 32'(seen), 32'd1);
      if (!seen) begin
        sb_q.delete();
        return;
      end
      check({e.tag, "_cycles"}, cyc, e.cyc);
      @(negedge clk);
      cyc = 1;
      check({e.tag, "_pc"}, 32'(pc), 32'(e.pc));
      check({e.tag, "_answer"}, answer, e.ans);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int  req_cnt, ret_cnt;
    bit  found;

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    reset_n  = 1'b0;
    rd_delay = 3;

    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_answer", answer, 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);

    put("addi_r2_5",  'h00, 32'h2002_0005, 30'h01, 32'h0000_0005, 4);
    put("j_20",       'h01, 32'h0800_0020, 30'h20, 32'h0000_0005, 2);
    put("sw_r2",      'h20, 32'hAC02_0008, 30'h21, 32'h0000_0005, 4);
    put("lw_r3_wait", 'h21, 32'h8C03_0008, 30'h22, 32'h0000_0005, 8);
    put("add_r3_r3",  'h22, 32'h0063_1020, 30'h23, 32'h0000_000A, 4);
    put("addi_r1_1",  'h23, 32'h2001_0001, 30'h24, 32'h0000_000A, 4);
    put("addi_r2_5b", 'h24, 32'h2002_0005, 30'h25, 32'h0000_0005, 4);
    put("j_4",        'h25, 32'h0800_0004, 30'h04, 32'h0000_0005, 2);
    put("bne_taken",  'h04, 32'h1422_FFFE, 30'h03, 32'h0000_0005, 3);
    put("j_30",       'h03, 32'h0800_0030, 30'h30, 32'h0000_0005, 2);
    put("beq_nt",     'h30, 32'h1022_0007, 30'h31, 32'h0000_0005, 3);
    put("beq_taken",  'h31, 32'h1021_0002, 30'h34, 32'h0000_0005, 3);
    put("j_10",       'h34, 32'h0800_0010, 30'h10, 32'h0000_0005, 2);
    put("jal_40",     'h10, 32'h0C00_0040, 30'h40, 32'h0000_0005, 2);
    put("jr_r31",     'h40, 32'h03E0_0008, 30'h11, 32'h0000_0005, 2);
    put("add_r31",    'h11, 32'h03E0_1020, 30'h12, 32'h0000_0044, 4);
    put("sub_neg",    'h12, 32'h0022_1022, 30'h13, 32'hFFFF_FFBD, 4);
    put("slt_signed", 'h13, 32'h0041_102A, 30'h14, 32'h0000_0001, 4);
    put("xori_zext",  'h14, 32'h3842_FFF0, 30'h15, 32'h0000_FFF1, 4);
    put("addi_r0",    'h15, 32'h2000_0009, 30'h16, 32'h0000_FFF1, 4);
    put("addi_neg1",  'h16, 32'h2002_FFFF, 30'h17, 32'hFFFF_FFFF, 4);
    mem['h17] = 32'hFC00_0000;

    @(posedge clk);
    #1 reset_n = 1'b1;
    drain();

    check("sw_count", w_cnt, 32'd1);
    check("sw_addr", 32'(w_addr), 32'd2);
    check("sw_data", w_data, 32'd5);
    check("sw_mem2", mem[2], 32'd5);
    check("lw_req_cycles", rd2_cyc, 32'd4);

    req_cnt = 0;
    ret_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) req_cnt++;
      if (retire) ret_cnt++;
    end
    check("trap_flag", 32'(trap), 32'd1);
    check("trap_no_req", req_cnt, 32'd0);
    check("trap_no_retire", ret_cnt, 32'd0);
    check("trap_pc", 32'(pc), 32'h18);
    check("trap_answer", answer, 32'hFFFF_FFFF);

    check("nop_first_retire", nt_first, 32'd2);
    check("nop_pc", 32'(nt_pc3), 32'd1);
    check("nop_answer", nt_ans3, 32'd0);
    check("nop_no_write", nt_wcnt, 32'd0);
    check("nop_trap", 32'(nt_trap), 32'd0);
    check("nop_then_addi", nt_answer, 32'd7);

    // Reset again and abandon an LW whose data read never acks.
    rd_delay = 1000;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    expect_retire("re_addi", 30'h01, 32'h0000_0005, 4);
    expect_retire("re_j_20", 30'h20, 32'h0000_0005, 2);
    expect_retire("re_sw", 30'h21, 32'h0000_0005, 4);
    drain();

    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && (mem_addr == 30'd2)) begin
        found = 1'b1;
        break;
      end
    end
    check("lw_stall_seen", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    check("lw_stall_req", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midreset_req", 32'(mem_req), 32'd0);
    check("midreset_addr", 32'(mem_addr), 32'd0);
    check("midreset_pc", 32'(pc), 32'd0);
    check("midreset_answer", answer, 32'd0);
    check("midreset_retire", 32'(retire), 32'd0);
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 force_ack = 1'b0;
    rd_delay = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    expect_retire("post_reset_addi", 30'h01, 32'h0000_0005, 4);
    drain();

    check("sw_total", w_cnt, 32'd2);
    check("handshake_stable", hs_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Multicycle MIPS-subset core; next generation of the single-cycle CPU top.
- Executes one instruction over 2–5 states. A single shared memory port with a req/ack handshake replaces the separate instruction and data memories, so memory latency is arbitrary.
- Word-address width and illegal-opcode handling are parametrised. Sits between a memory/arbiter and the test harness; the `answer` output (r2) is kept for bench checking.

Parameters:
- ADDR_W, 30, word-address width of PC and mem_addr; legal range 8..30.
- RESET_PC, 0, word address loaded into PC on reset.
- TRAP_ON_ILLEGAL, 1, 1 = illegal opcode/funct enters TRAP; 0 = it retires as NOP.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- mem_req  out  1  memory request, held until acked
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, valid in ack cycle
- mem_ack  in  1  request completes at this edge
- retire  out  1  one-cycle pulse in each instruction's last state
- trap  out  1  sticky; high in TRAP state
- pc  out  ADDR_W  current PC, word address
- answer  out  32  register r2

Behaviour:
- Reset: async, reset_n=0 forces the following immediately, regardless of state or pending handshake. State=FETCH, pc=RESET_PC, IR/A/B/ALUout=0, all 32 registers=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, trap=0. An abandoned memory request is dropped.
- First mem_req asserts in the first cycle after reset_n rises.
- Handshake: while mem_req=1, mem_addr, mem_we and mem_wdata stay stable. The transfer completes at the rising edge where mem_ack=1. mem_ack while mem_req=0 is ignored. Zero-wait means ack in the same cycle as req.
- FETCH: req read at pc. On ack: IR<=mem_rdata, pc<=pc+1, go to DECODE.
- DECODE: A<=R[rs], B<=R[rt].
  - J/JAL: pc<={pc[ADDR_W-1:26], target26}, truncated to ADDR_W if ADDR_W≤26. JAL writes R31<={pc,2'b00}, where pc is the already-incremented value. Retire, go to FETCH.
  - JR: pc<=R[rs][ADDR_W+1:2]. Retire, go to FETCH.
  - Illegal encoding: go to TRAP (TRAP_ON_ILLEGAL=1), or retire → FETCH (TRAP_ON_ILLEGAL=0).
  - Otherwise go to EXEC.
- EXEC:
  - ALUout per operation. ADD/SUB wrap with overflow ignored; SLT is signed; ADDI and address calculation use sign-extended imm; XORI uses zero-extended imm.
  - BEQ/BNE: compare A and B. If taken, pc<=pc+sext(imm16), word units, modulo 2^ADDR_W. Retire, go to FETCH.
  - LW/SW go to MEM; all others go to WB.
- MEM: mem_addr=ALUout[ADDR_W+1:2]; the low two bits are ignored.
  - SW: mem_we=1, mem_wdata=B. On ack, retire and go to FETCH.
  - LW: on ack, MDR<=mem_rdata, go to WB.
- WB:
  - R-type writes R[rd]<=ALUout; I-type writes R[rt]<=ALUout (or MDR for LW).
  - Writes to r0 are discarded; r0 always reads 0.
  - Retire, go to FETCH.
- TRAP: absorbing state until reset. trap=1, mem_req=0, retire never pulses.
- Latency with zero-wait memory: J/JAL/JR 2 cycles; BEQ/BNE 3; R-type/ADDI/XORI 4; SW 4; LW 5. Each memory wait cycle adds 1.
- Encodings:
  - Opcodes: R=0x00, J=0x02, JAL=0x03, BEQ=0x04, BNE=0x05, ADDI=0x08, XORI=0x0E, LW=0x23, SW=0x2B.
  - R-type funct: JR=0x08, ADD=0x20, SUB=0x22, SLT=0x2A.
  - Any other opcode or funct is illegal.
- Register file: two combinational read ports; the single write port updates at the clock edge.

Decomposition:
- Package cpu_pkg holds:
  - opcode and funct localparams;
  - state enum FETCH/DECODE/EXEC/MEM/WB/TRAP;
  - ALU op enum ADD/SUB/SLT/XOR.
- Sub-module mc_regfile:
  - 32x32 registers, 2 read ports, 1 write port;
  - r0 hardwired to 0;
  - async active-low clear;
  - exposes r2 as `answer`.
- ALU and FSM stay inline in multicycle_cpu.

Test Plan:
- Reset, then ADDI r2,r0,5 (0x20020005) with zero-wait ack → retire pulses in cycle 4, answer=5, pc=1.
- SW r2,8(r0) after the test above → MEM cycle shows mem_req=1, mem_we=1, mem_addr=2, mem_wdata=5. Then LW r3,8(r0) with ack delayed 3 cycles → mem_addr held at 2 throughout, instruction takes 8 cycles, r3=5.
- r1=1, r2=5; BNE r1,r2,-2 at pc=4 → pc=3, retire at cycle 3. Then BEQ r1,r2,+7 → pc increments only.
- JAL 0x40 at pc=0x10 → pc=0x40, R31=0x44, 2 cycles. Then JR r31 → pc=0x11.
- Opcode 0x3F:
  - TRAP_ON_ILLEGAL=1 → trap=1, mem_req stays 0, no retire.
  - TRAP_ON_ILLEGAL=0 → retire, pc+1, no register or memory change.
- Assert reset_n=0 while an LW is waiting for ack → mem_req drops the same cycle, pc=RESET_PC, answer=0. The late ack is ignored, and fetch restarts after reset_n rises.
